// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types, tables and round/key-schedule helper functions.
package aes_pkg;

    typedef logic [127:0] aes_block_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:9][7:0] RCON = 80'h01020408102040801b36;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aes_block_t sub_bytes(input aes_block_t s);
        aes_block_t o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = SBOX[s[8*i +: 8]];
        return o;
    endfunction

    // Byte n sits at bits [127-8n -: 8]; the state is column-major, row = n % 4.
    function automatic aes_block_t shift_rows(input aes_block_t s);
        aes_block_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3, t;
        {a0, a1, a2, a3} = w;
        t = a0 ^ a1 ^ a2 ^ a3;
        return {a0 ^ t ^ xtime(a0 ^ a1), a1 ^ t ^ xtime(a1 ^ a2),
                a2 ^ t ^ xtime(a2 ^ a3), a3 ^ t ^ xtime(a3 ^ a0)};
    endfunction

    function automatic aes_block_t mix_columns(input aes_block_t s);
        aes_block_t o;
        for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
        return o;
    endfunction

    function automatic aes_block_t key_step(input aes_block_t k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {SBOX[k[23:16]], SBOX[k[15:8]], SBOX[k[7:0]], SBOX[k[31:24]]} ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_round_step.sv
// aes_round_step: one combinational AES round plus the matching key-expansion step.
module aes_round_step
    import aes_pkg::*;
#(
    parameter int RND = 1
) (
    input  aes_block_t i_state,
    input  aes_block_t i_key,
    output aes_block_t o_state,
    output aes_block_t o_key
);
    aes_block_t w_sr;

    assign o_key = key_step(i_key, RCON[RND-1]);
    assign w_sr  = shift_rows(sub_bytes(i_state));

    if (RND == 10) begin : g_final
        assign o_state = w_sr ^ o_key;
    end else begin : g_mid
        assign o_state = mix_columns(w_sr) ^ o_key;
    end
endmodule

// File: rtl/aes128_pipe_stream.sv
// aes128_pipe_stream: never-stalling AES-128 pipeline with per-block key/tag and a
// credit-throttled output FIFO, so downstream backpressure cannot drop a block.
module aes128_pipe_stream
    import aes_pkg::*;
#(
    parameter int RPS        = 1,
    parameter int TAG_W      = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    input  logic [127:0]     in_key,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int NSTG = 10 / RPS;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int EW   = 128 + TAG_W;

    if (RPS != 1 && RPS != 2 && RPS != 5 && RPS != 10) begin : g_bad_rps
        $error("aes128_pipe_stream: RPS must be 1, 2, 5 or 10");
    end
    if (FIFO_DEPTH < 2) begin : g_bad_depth
        $error("aes128_pipe_stream: FIFO_DEPTH must be at least 2");
    end

    logic [NSTG:0]    r_vld;
    aes_block_t       r_st  [NSTG+1];
    aes_block_t       r_key [NSTG];
    logic [TAG_W-1:0] r_tag [NSTG+1];
    logic [CW-1:0]    r_cred, r_cnt;
    logic [AW-1:0]    r_wp, r_rp;
    logic [EW-1:0]    r_mem [FIFO_DEPTH];
    logic             w_acc, w_pop, w_wr;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credits count free FIFO slots not yet claimed by an in-flight block.
    assign in_ready  = reset && (r_cred != '0);
    assign w_acc     = in_valid && in_ready;
    assign out_valid = (r_cnt != '0);
    assign w_pop     = out_valid && out_ready;
    assign w_wr      = r_vld[NSTG];
    assign busy      = (|r_vld) || out_valid;
    assign {out_data, out_tag} = out_valid ? r_mem[r_rp] : '0;

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_st[0]  <= in_data ^ in_key;
            r_key[0] <= in_key;
            r_tag[0] <= in_tag;
        end
    end

    for (genvar s = 1; s <= NSTG; s++) begin : g_stg
        aes_block_t w_st [RPS+1];
        aes_block_t w_k  [RPS+1];
        assign w_st[0] = r_st[s-1];
        assign w_k[0]  = r_key[s-1];
        for (genvar r = 0; r < RPS; r++) begin : g_rnd
            aes_round_step #(.RND((s - 1) * RPS + r + 1)) u_step (
                .i_state(w_st[r]),
                .i_key  (w_k[r]),
                .o_state(w_st[r+1]),
                .o_key  (w_k[r+1])
            );
        end
        always_ff @(posedge clk) begin
            r_st[s]  <= w_st[RPS];
            r_tag[s] <= r_tag[s-1];
        end
        if (s < NSTG) begin : g_key
            always_ff @(posedge clk) r_key[s] <= w_k[RPS];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_vld  <= '0;
            r_cred <= CW'(FIFO_DEPTH);
            r_cnt  <= '0;
            r_wp   <= '0;
            r_rp   <= '0;
        end else begin
            r_vld  <= {r_vld[NSTG-1:0], w_acc};
            r_cred <= r_cred - CW'(w_acc) + CW'(w_pop);
            r_cnt  <= r_cnt + CW'(w_wr) - CW'(w_pop);
            if (w_wr)  r_wp <= inc(r_wp);
            if (w_pop) r_rp <= inc(r_rp);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp] <= {r_st[NSTG], r_tag[NSTG]};
    end
endmodule

// File: tb/tb_aes128_pipe_stream.sv
// tb_aes128_pipe_stream: scoreboard bench over five DUT configurations
// (RPS 1/2/5/10 with depth 16, and RPS 1 with depth 4 for backpressure).
module tb_aes128_pipe_stream;
    localparam int N = 5;
    localparam int RPS_T [N] = '{1, 2, 5, 10, 1};
    localparam int DEP_T [N] = '{16, 16, 16, 16, 4};
    localparam logic [127:0] VK [3] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h0,
                                        128'h2b7e151628aed2a6abf7158809cf4f3c};
    localparam logic [127:0] VP [3] = '{128'h00112233445566778899aabbccddeeff, 128'h0,
                                        128'h3243f6a8885a308d313198a2e0370734};
    localparam logic [127:0] VC [3] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                                        128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                                        128'h3925841d02dc09fbdc118597196a0b32};

    typedef struct {
        logic [127:0] d;
        logic [7:0]   t;
        int           c;
        int           g;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] vin = '0;
    logic [N-1:0] ordy = '1;
    logic [N-1:0] iry, ov, bsy;
    logic [127:0] din = '0, kin = '0;
    logic [7:0]   tin = '0;
    logic [127:0] od [N];
    logic [7:0]   ot [N];
    exp_t         sb [$];
    int           total = 0, bad = 0, cyc = 0, outst = 0, pops = 0;
    bit           lat_on = 1'b0, inv_on = 1'b0, rnd_done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        aes128_pipe_stream #(.RPS(RPS_T[g]), .TAG_W(8), .FIFO_DEPTH(DEP_T[g])) u_dut (
            .clk(clk), .reset(reset),
            .in_valid(vin[g]), .in_ready(iry[g]), .in_data(din), .in_key(kin), .in_tag(tin),
            .out_valid(ov[g]), .out_ready(ordy[g]), .out_data(od[g]), .out_tag(ot[g]),
            .busy(bsy[g])
        );
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input int g, input int v, input logic [7:0] t);
        int n = 0;
        din = VP[v];
        kin = VK[v];
        tin = t;
        vin[g] = 1'b1;
        @(negedge clk);
        while (!iry[g] && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!iry[g]) chk("send_timeout", iry[g], 1'b1);
        else sb.push_back('{VC[v], t, cyc + 1, g});
        @(posedge clk);
        #1 vin[g] = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every pop is compared to the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) outst = 0;
            else begin
                if (inv_on) chk("credit", iry[0], outst != 16);
                outst += int'(vin[0] && iry[0]) - int'(ov[0] && ordy[0]);
            end
            for (int g = 0; g < N; g++) begin
                if (ov[g] && ordy[g]) begin
                    if (sb.size() == 0) chk("unexpected_pop", ov[g], 1'b0);
                    else begin
                        e = sb.pop_front();
                        chk("data", od[g], e.d);
                        chk("tag", ot[g], e.t);
                        chk("dut_idx", g, e.g);
                        if (lat_on) chk("latency", cyc + 1 - e.c, 10 / RPS_T[g] + 2);
                        pops++;
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int acc, p0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", iry, 5'h00);
        chk("rst_out_valid", ov, 5'h00);
        chk("rst_busy", bsy, 5'h00);
        chk("rst_out_data", od[0], 128'h0);
        chk("rst_out_tag", ot[0], 8'h00);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", iry, 5'h1f);
        @(posedge clk);
        #1;

        lat_on = 1'b1;
        send(0, 0, 8'h5a);
        drain("c1_drain");
        for (int g = 1; g < 4; g++) begin
            send(g, 1, 8'(g));
            drain("zero_drain");
        end
        p0 = pops;
        for (int i = 0; i < 10; i++) send(0, i % 2, 8'(i));
        drain("stream_drain");
        chk("stream_count", pops - p0, 10);
        lat_on = 1'b0;

        ordy[4] = 1'b0;
        vin[4] = 1'b1;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            din = VP[acc % 3];
            kin = VK[acc % 3];
            tin = 8'(100 + acc);
            @(negedge clk);
            if (iry[4]) begin
                sb.push_back('{VC[acc % 3], 8'(100 + acc), 0, 4});
                acc++;
            end
            @(posedge clk);
            #1;
        end
        vin[4] = 1'b0;
        chk("bp_accepts", acc, 4);
        chk("bp_in_ready", iry[4], 1'b0);
        chk("bp_out_valid", ov[4], 1'b1);
        p0 = pops;
        ordy[4] = 1'b1;
        drain("bp_drain");
        chk("bp_popped", pops - p0, 4);
        @(negedge clk);
        chk("bp_recover", iry[4], 1'b1);
        @(posedge clk);
        #1;

        inv_on = 1'b1;
        p0 = pops;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    while ($urandom_range(1) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(0, int'($urandom_range(2)), 8'(i));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    ordy[0] = 1'($urandom_range(1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        ordy[0] = 1'b1;
        drain("rnd_drain");
        inv_on = 1'b0;
        chk("rnd_count", pops - p0, 1000);

        ordy[0] = 1'b0;
        for (int i = 0; i < 8; i++) send(0, 2, 8'(200 + i));
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("pre_rst_out_valid", ov[0], 1'b1);
        chk("pre_rst_busy", bsy[0], 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("in_rst_in_ready", iry[0], 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", ov[0], 1'b0);
        chk("mid_rst_busy", bsy[0], 1'b0);
        chk("mid_rst_in_ready", iry[0], 1'b1);
        chk("mid_rst_out_data", od[0], 128'h0);
        chk("mid_rst_out_tag", ot[0], 8'h00);
        ordy[0] = 1'b1;
        repeat (30) @(negedge clk);
        @(posedge clk);
        #1 lat_on = 1'b1;
        send(0, 0, 8'hc3);
        drain("post_rst_drain");
        lat_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
